// File: rtl/neuron_accumulator.sv
// Signed MAC stage for one layer: accumulates n_in weight*neuron products per output
// neuron, then shifts, optionally rectifies, saturates and writes one result per neuron.
module neuron_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = 4,
  parameter int RELU      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [7:0]               n_in,
  input  logic [7:0]               n_out,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] weight_data,
  input  logic signed [DATA_W-1:0] neuro_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     sat
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic signed [ACC_W-1:0]  MAX_V = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0]  MIN_V = ~MAX_V;
  localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                     state;
  logic signed [ACC_W-1:0]    acc;
  logic [7:0]                 in_cnt;
  logic [7:0]                 out_cnt;
  logic [7:0]                 n_in_lat;
  logic [7:0]                 n_out_lat;

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [DATA_W-1:0]   result;
  logic                       clamped;
  logic                       complete;
  logic                       last_neuron;

  always_comb begin
    product = weight_data * neuro_data;
    // The completing pair is folded in here so the finished sum is available the same cycle.
    if (n_in_lat == 8'd0)
      sum = '0;
    else
      sum = acc + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

    complete = (state == ACCUM) &&
               ((n_in_lat == 8'd0) ||
                (in_valid && (({1'b0, in_cnt} + 9'd1) == {1'b0, n_in_lat})));
    last_neuron = (({1'b0, out_cnt} + 9'd1) == {1'b0, n_out_lat});

    shifted = sum >>> FRAC_BITS;
    if (RELU != 0 && shifted[ACC_W-1])
      shifted = '0;

    clamped = 1'b0;
    result  = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      result  = MAX_D;
      clamped = 1'b1;
    end else if (shifted < MIN_V) begin
      result  = MIN_D;
      clamped = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      n_in_lat  <= '0;
      n_out_lat <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      // A load always restarts the layer, even over a completing pair in the same cycle.
      if (load) begin
        acc       <= '0;
        in_cnt    <= '0;
        out_cnt   <= '0;
        sat       <= 1'b0;
        n_in_lat  <= n_in;
        n_out_lat <= n_out;
        if (n_out != 8'd0) begin
          state <= ACCUM;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (state == ACCUM) begin
        if (complete) begin
          acc     <= '0;
          in_cnt  <= '0;
          wr_en   <= 1'b1;
          wr_addr <= ADDR_W'(out_cnt);
          wr_data <= result;
          out_cnt <= out_cnt + 8'd1;
          if (clamped)
            sat <= 1'b1;
          if (last_neuron) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end else if (in_valid) begin
          acc    <= sum;
          in_cnt <= in_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Checks two accumulator instances (ReLU on / off) against a per-neuron arithmetic model
// using directed layers from the test plan plus randomized layers.
module tb_neuron_accumulator;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load = 1'b0;
  logic [7:0]        n_in = '0;
  logic [7:0]        n_out = '0;
  logic              in_valid = 1'b0;
  logic signed [7:0] w = '0;
  logic signed [7:0] x = '0;

  logic              en_r, busy_r, done_r, sat_r;
  logic [7:0]        addr_r, data_r;
  logic              en_s, busy_s, done_s, sat_s;
  logic [7:0]        addr_s, data_s;

  neuron_accumulator #(.RELU(1)) dut_r (
    .clk(clk), .reset(reset), .load(load), .n_in(n_in), .n_out(n_out),
    .in_valid(in_valid), .weight_data(w), .neuro_data(x),
    .wr_en(en_r), .wr_addr(addr_r), .wr_data(data_r),
    .busy(busy_r), .done(done_r), .sat(sat_r)
  );

  neuron_accumulator #(.RELU(0)) dut_s (
    .clk(clk), .reset(reset), .load(load), .n_in(n_in), .n_out(n_out),
    .in_valid(in_valid), .weight_data(w), .neuro_data(x),
    .wr_en(en_s), .wr_addr(addr_s), .wr_data(data_s),
    .busy(busy_s), .done(done_s), .sat(sat_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         stamp;
    logic       en_r, en_s, done_r, done_s, busy_r, busy_s;
    logic [7:0] addr_r, addr_s, d_r, d_s;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  ev_t mon_e;

  always @(negedge clk) begin
    if (en_r | en_s | done_r | done_s) begin
      mon_e        = '0;
      mon_e.stamp  = cyc;
      mon_e.en_r   = en_r;
      mon_e.en_s   = en_s;
      mon_e.done_r = done_r;
      mon_e.done_s = done_s;
      mon_e.busy_r = busy_r;
      mon_e.busy_s = busy_s;
      mon_e.addr_r = en_r ? addr_r : 8'd0;
      mon_e.addr_s = en_s ? addr_s : 8'd0;
      mon_e.d_r    = en_r ? data_r : 8'd0;
      mon_e.d_s    = en_s ? data_s : 8'd0;
      got_q.push_back(mon_e);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model state for the layer in progress
  longint acc_m;
  int     cnt_m, k_m, ni_m, no_m;
  bit     sat_r_m, sat_s_m;

  function automatic void act(input longint sum, input bit relu, output logic [7:0] d, output bit s);
    longint r;
    r = sum >>> 4;
    if (relu && r < 0) r = 0;
    s = 1'b0;
    if (r > 127) begin
      r = 127; s = 1'b1;
    end else if (r < -128) begin
      r = -128; s = 1'b1;
    end
    d = r[7:0];
  endfunction

  task automatic push_neuron(input longint sum, input int stamp);
    ev_t e;
    logic [7:0] dr, ds;
    bit sr, ss;
    act(sum, 1'b1, dr, sr);
    act(sum, 1'b0, ds, ss);
    sat_r_m |= sr;
    sat_s_m |= ss;
    e        = '0;
    e.stamp  = stamp;
    e.en_r   = 1'b1;
    e.en_s   = 1'b1;
    e.addr_r = 8'(k_m);
    e.addr_s = 8'(k_m);
    e.d_r    = dr;
    e.d_s    = ds;
    e.done_r = (k_m == no_m - 1);
    e.done_s = e.done_r;
    e.busy_r = !e.done_r;
    e.busy_s = !e.done_r;
    exp_q.push_back(e);
    k_m++;
  endtask

  task automatic model_reset(input int ni, input int no);
    ni_m = ni; no_m = no; acc_m = 0; cnt_m = 0; k_m = 0;
    sat_r_m = 1'b0; sat_s_m = 1'b0;
  endtask

  task automatic start_layer(input int ni, input int no);
    ev_t e;
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    load = 1'b1; n_in = 8'(ni); n_out = 8'(no); in_valid = 1'b0;
    model_reset(ni, no);
    if (no == 0) begin
      e = '0;
      e.stamp = cyc + 1;
      e.done_r = 1'b1;
      e.done_s = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    load = 1'b0;
    chk("busy_after_load", 128'(busy_r), 128'(no != 0));
    if (ni == 0)
      for (int k = 0; k < no; k++) push_neuron(0, cyc + 1 + k);
  endtask

  task automatic pair(input logic signed [7:0] wv, input logic signed [7:0] xv);
    in_valid = 1'b1; w = wv; x = xv;
    acc_m += longint'(wv) * longint'(xv);
    cnt_m++;
    if (cnt_m == ni_m) begin
      push_neuron(acc_m, cyc + 1);
      acc_m = 0;
      cnt_m = 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    w = 8'($urandom);
    x = 8'($urandom);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_layer(input string tag);
    idle(4);
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      $display("[TB] %s ev%0d t=%0d wr=%0d addr=%0d data_r=%0d data_s=%0d done=%0d",
               tag, i, got_q[i].stamp, got_q[i].en_r, got_q[i].addr_r,
               $signed(got_q[i].d_r), $signed(got_q[i].d_s), got_q[i].done_r);
      chk($sformatf("%s_ev%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    end
    chk({tag, "_sat_r"}, 128'(sat_r), 128'(sat_r_m));
    chk({tag, "_sat_s"}, 128'(sat_s), 128'(sat_s_m));
  endtask

  task automatic rand_layer(input string tag);
    int ni, no;
    ni = $urandom_range(1, 6);
    no = $urandom_range(1, 4);
    start_layer(ni, no);
    for (int k = 0; k < no; k++)
      for (int j = 0; j < ni; j++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        pair(8'($urandom), 8'($urandom));
      end
    finish_layer(tag);
  endtask

  initial begin
    #2;
    chk("reset_r", 128'({en_r, addr_r, data_r, busy_r, done_r, sat_r}), 128'(0));
    chk("reset_s", 128'({en_s, addr_s, data_s, busy_s, done_s, sat_s}), 128'(0));
    #10 reset = 1'b1;

    // Basic MAC: 768>>>4 = 48; -1536>>>4 = -96 (0 with ReLU)
    start_layer(3, 2);
    repeat (3) pair(16, 16);
    repeat (3) pair(-16, 32);
    finish_layer("basic");

    start_layer(2, 1);
    repeat (2) pair(127, 127);
    finish_layer("sat_pos");

    start_layer(2, 1);
    repeat (2) pair(-128, 127);
    finish_layer("sat_neg");

    start_layer(3, 0);
    chk("nout0_busy", 128'(busy_r | busy_s), 128'(0));
    finish_layer("nout0");

    start_layer(0, 3);
    finish_layer("nin0");

    start_layer(4, 1);
    pair(16, 16); idle(2); pair(16, 16); pair(16, 16); idle(1); pair(16, 16);
    finish_layer("gap");

    // Abort: neuron 0 saturates and writes, then a load lands on neuron 1's final pair
    start_layer(2, 2);
    repeat (2) pair(127, 127);
    pair(16, 16);
    chk("abort_sat_before", 128'(sat_r), 128'(1));
    in_valid = 1'b1; w = 16; x = 16;
    load = 1'b1; n_in = 8'd1; n_out = 8'd1;
    model_reset(1, 1);
    @(posedge clk); #1;
    load = 1'b0; in_valid = 1'b0;
    pair(32, 16);
    finish_layer("abort");

    for (int i = 0; i < 6; i++) rand_layer($sformatf("rand%0d", i));

    // Asynchronous reset in the middle of a layer
    start_layer(1, 3);
    repeat (2) pair(127, 127);
    chk("pre_reset_busy", 128'(busy_r), 128'(1));
    chk("pre_reset_sat", 128'(sat_r), 128'(1));
    #2 reset = 1'b0;
    #1;
    chk("async_reset_r", 128'({en_r, addr_r, data_r, busy_r, done_r, sat_r}), 128'(0));
    chk("async_reset_s", 128'({en_s, addr_s, data_s, busy_s, done_s, sat_s}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    rand_layer("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

- Write-side consumer of the layer address stream.
- Receives the weight/neuron operand pairs fetched at the generated read addresses.
- Runs a signed multiply-accumulate over the inputs of each output neuron, then applies shift, ReLU and saturation.
- Emits one write (address, data) per output neuron into the next-layer neuron memory.
- Sits between the weight/neuron RAM read ports and the neuron RAM write port of one layer stage.

## Interface
- DATA_W, 8, operand and result width (signed, two's complement)
- ADDR_W, 8, neuron write address width
- ACC_W, 24, accumulator width (signed)
- FRAC_BITS, 4, fractional bits of the operand format; result = acc >>> FRAC_BITS
- RELU, 1, 1 = clamp negative results to 0; 0 = signed output

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- load  input  1  one-cycle strobe; samples n_in/n_out, starts a layer
- n_in  input  8  inputs per neuron (products per output)
- n_out  input  8  output neurons in layer
- in_valid  input  1  weight_data/neuro_data valid this cycle
- weight_data  input  DATA_W  signed weight operand
- neuro_data  input  DATA_W  signed neuron operand
- wr_en  output  1  write strobe, one cycle per neuron
- wr_addr  output  ADDR_W  neuron index being written
- wr_data  output  DATA_W  activated, saturated result
- busy  output  1  layer in progress
- done  output  1  one-cycle pulse with final write
- sat  output  1  sticky: a result was clamped this layer; cleared by load

## Operation
- States: IDLE, ACCUM.
- IDLE -> ACCUM on load with n_out != 0.
- load with n_out == 0: stay IDLE, pulse done next cycle, no wr_en.
- load in any state aborts the current layer:
  - clears acc, in_cnt, out_cnt and sat;
  - relatches n_in/n_out;
  - no done is issued for the aborted layer.
- In ACCUM, each cycle with in_valid=1:
  - product = weight_data * neuro_data, 2*DATA_W signed, sign-extended to ACC_W;
  - acc += product (wraps modulo 2^ACC_W, no internal saturation);
  - in_cnt += 1.
- On the n_in-th accepted pair:
  - the completed sum (including this pair) goes to the output stage;
  - acc and in_cnt clear the same edge;
  - the next neuron accumulates from the following cycle with no bubble.
- n_in == 0: each ACCUM cycle completes one neuron with sum 0, independent of in_valid.
- Output stage: r = acc_final >>> FRAC_BITS (arithmetic).
  - If RELU and r < 0, then r = 0.
  - Clamp r to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1]; set sat if clamped.
- wr_addr = out_cnt, the index of the completed neuron. out_cnt increments after each completed neuron.
- After neuron n_out-1 completes:
  - done pulses with its wr_en;
  - return to IDLE.
- in_valid is ignored in IDLE.
- Reset to default (all outputs 0, IDLE) on reset=0 at any time, regardless of clk.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, sat=0, state IDLE.
- load sampled at edge t:
  - busy=1 from t+1;
  - first pair accepted at t+1 at the earliest.
- Last pair of neuron k accepted at edge c:
  - wr_en=1, wr_addr=k, wr_data valid during cycle c+1 (one-cycle registered latency);
  - wr_en is high for exactly one cycle per neuron.
- Back-to-back neurons with continuous in_valid give wr_en every n_in cycles.
- Final neuron: done=1 and busy=0 in the same cycle as its wr_en. The next load is accepted that cycle.
- in_valid gaps stall accumulation only; no timeout.
- load coincident with the final pair: the load wins. No wr_en, no done.

## Test plan
- Basic MAC:
  - Stimulus: RELU=1, n_in=3, n_out=2. Neuron 0 gets three pairs (16,16); neuron 1 gets three pairs (-16,32).
  - Expected: wr (addr 0, data 48) then wr (addr 1, data 0, ReLU). done coincides with the second wr_en. sat=0.
- Saturation:
  - Stimulus: n_in=2, n_out=1, pairs (127,127) x2. acc=32258, shifted 2016.
  - Expected: wr_data=127, sat=1.
  - With RELU=0 and pairs (-128,127) x2: wr_data=-128, sat=1.
- Degenerate sizes:
  - Stimulus: n_out=0.
  - Expected: done one cycle after load, no wr_en, busy stays 0.
  - Stimulus: n_in=0, n_out=3.
  - Expected: wr_data=0 at addrs 0, 1, 2 on three consecutive cycles; done with addr 2.
- Gapped valid:
  - Stimulus: n_in=4, in_valid pattern 1,0,0,1,1,0,1, all pairs (16,16).
  - Expected: single wr_en one cycle after the 4th valid, data 64.
- Abort:
  - Stimulus: load mid-neuron with new n_in=1, n_out=1, then pair (32,16).
  - Expected: no write for the old layer; wr (addr 0, data 32); done.
- Reset:
  - Stimulus: drive reset=0 asynchronously mid-layer.
  - Expected: all outputs 0 immediately. After release, a full layer runs correctly.
